// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS count-down timer.
// Imported by the top level and the button front end.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  localparam logic [2:0] DIG_NONE = 3'd0;
  localparam logic [2:0] DIG_1    = 3'd1;
  localparam logic [2:0] DIG_2    = 3'd2;
  localparam logic [2:0] DIG_3    = 3'd3;
  localparam logic [2:0] DIG_4    = 3'd4;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_NINE) ? BCD_NINE : v;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge pulse for one pushbutton.
// The pulse is one CLK wide, two edges after the button is sampled.
module btn_edge
  import countdown_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync0_q;
  logic sync1_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= btn_i;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
    end
  end

  assign pulse_o = sync1_q & ~prev_q;

endmodule

// File: rtl/countdowntime.sv
// MM:SS count-down timer with alarm and a four-digit scan output.
// Single clock domain; prescalers produce the 1 Hz tick and scan rate.
module countdowntime
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic [7:0] SW,
  output logic [4:0] data,
  output logic [2:0] digit,
  output logic       setdp,
  output logic       ALARM
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SWD = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [SWD-1:0] SLAST = SWD'(SCAN_DIV - 1);

  logic start_p, pause_p, load_p;

  btn_edge u_btnl (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTNL),
    .pulse_o(start_p)
  );

  btn_edge u_btnr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTNR),
    .pulse_o(pause_p)
  );

  btn_edge u_btnd (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTND),
    .pulse_o(load_p)
  );

  state_e state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [SWD-1:0] scan_q, scan_d;
  logic [1:0] dmux_q, dmux_d;
  logic [3:0] min10_q, min10_d;
  logic [3:0] min1_q, min1_d;
  logic [3:0] sec10_q, sec10_d;
  logic [3:0] sec1_q, sec1_d;
  logic [3:0] data_q, data_d;
  logic [2:0] digit_q, digit_d;
  logic setdp_q, setdp_d;

  logic [3:0] dm10, dm1, ds10, ds1;
  logic tick, cnt_zero, dec_zero, scan_wrap;

  // BCD borrow chain: one second less than the current count
  always_comb begin
    dm10 = min10_q;
    dm1  = min1_q;
    ds10 = sec10_q;
    ds1  = sec1_q - 4'd1;
    if (sec1_q == 4'd0) begin
      ds1  = BCD_NINE;
      ds10 = sec10_q - 4'd1;
      if (sec10_q == 4'd0) begin
        ds10 = BCD_FIVE;
        dm1  = min1_q - 4'd1;
        if (min1_q == 4'd0) begin
          dm1  = BCD_NINE;
          dm10 = min10_q - 4'd1;
        end
      end
    end
  end

  assign cnt_zero = ({min10_q, min1_q, sec10_q, sec1_q} == 16'd0);
  assign dec_zero = ({dm10, dm1, ds10, ds1} == 16'd0);
  assign tick     = (state_q == RUN) && (presc_q == TLAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    if (load_p) begin
      state_d = IDLE;
      presc_d = '0;
      min10_d = bcd_clamp(SW[7:4]);
      min1_d  = bcd_clamp(SW[3:0]);
      sec10_d = 4'd0;
      sec1_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_p && !cnt_zero) state_d = RUN;
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + TW'(1);
          if (tick) begin
            min10_d = dm10;
            min1_d  = dm1;
            sec10_d = ds10;
            sec1_d  = ds1;
          end
          // reaching zero wins over a same-cycle pause
          if (tick && dec_zero) state_d = DONE;
          else if (pause_p)     state_d = PAUSE;
        end
        PAUSE: begin
          if (start_p) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign scan_wrap = (scan_q == SLAST);

  always_comb begin
    scan_d  = scan_wrap ? '0 : scan_q + SWD'(1);
    dmux_d  = dmux_q;
    data_d  = data_q;
    digit_d = digit_q;
    setdp_d = setdp_q;
    if (scan_wrap) begin
      dmux_d = dmux_q + 2'd1;
      unique case (dmux_q)
        2'd0: begin data_d = sec1_q;  digit_d = DIG_1; setdp_d = 1'b0; end
        2'd1: begin data_d = sec10_q; digit_d = DIG_2; setdp_d = 1'b0; end
        2'd2: begin data_d = min1_q;  digit_d = DIG_3; setdp_d = 1'b1; end
        2'd3: begin data_d = min10_q; digit_d = DIG_4; setdp_d = 1'b0; end
        default: begin data_d = 4'd0; digit_d = DIG_NONE; setdp_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      presc_q <= '0;
      scan_q  <= '0;
      dmux_q  <= 2'd0;
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
      sec10_q <= 4'd0;
      sec1_q  <= 4'd0;
      data_q  <= 4'd0;
      digit_q <= DIG_NONE;
      setdp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      dmux_q  <= dmux_d;
      min10_q <= min10_d;
      min1_q  <= min1_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
      data_q  <= data_d;
      digit_q <= digit_d;
      setdp_q <= setdp_d;
    end
  end

  assign data  = {1'b0, data_q};
  assign digit = digit_q;
  assign setdp = setdp_q;
  assign ALARM = (state_q == DONE);

endmodule

// File: tb/tb_countdowntime.sv
// Bench for countdowntime: seconds-based reference model, load table,
// hand-written corner sequences and randomized button traffic.
module tb_countdowntime;

  localparam int TD = 10;
  localparam int SD = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTNL, BTNR, BTND;
  logic [7:0] SW;
  logic [4:0] data;
  logic [2:0] digit;
  logic       setdp;
  logic       ALARM;

  countdowntime #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BTNL (BTNL),
    .BTNR (BTNR),
    .BTND (BTND),
    .SW   (SW),
    .data (data),
    .digit(digit),
    .setdp(setdp),
    .ALARM(ALARM)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model: count kept as total seconds
  int m_total = 0;
  int m_st = S_IDLE;
  int m_pc = 0;
  int m_sc = 0;
  int m_dm = 0;
  int m_data = 0;
  int m_dig = 0;
  int m_dp = 0;
  logic [2:0] hL = '0, hR = '0, hD = '0;
  logic pl, pr, pd;
  int old_total;

  function automatic int clamp9(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  function automatic int digit_of(input int total, input int pos);
    int m, s;
    m = total / 60;
    s = total % 60;
    case (pos)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      default: return m / 10;
    endcase
  endfunction

  function automatic logic [15:0] model_cnt();
    return {4'(digit_of(m_total, 3)), 4'(digit_of(m_total, 2)),
            4'(digit_of(m_total, 1)), 4'(digit_of(m_total, 0))};
  endfunction

  function automatic logic [15:0] cnt_act();
    return {dut.min10_q, dut.min1_q, dut.sec10_q, dut.sec1_q};
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_total = 0; m_st = S_IDLE; m_pc = 0; m_sc = 0; m_dm = 0;
      m_data = 0; m_dig = 0; m_dp = 0;
      hL = '0; hR = '0; hD = '0;
    end else begin
      pl = hL[1] & ~hL[2];
      pr = hR[1] & ~hR[2];
      pd = hD[1] & ~hD[2];
      old_total = m_total;
      if (m_sc == SD - 1) begin
        m_data = digit_of(old_total, m_dm);
        m_dig = m_dm + 1;
        m_dp = (m_dm == 2) ? 1 : 0;
        m_dm = (m_dm + 1) % 4;
        m_sc = 0;
      end else begin
        m_sc++;
      end
      if (pd) begin
        m_total = clamp9(int'(SW[7:4])) * 600 + clamp9(int'(SW[3:0])) * 60;
        m_st = S_IDLE;
        m_pc = 0;
      end else begin
        case (m_st)
          S_IDLE: if (pl && m_total != 0) m_st = S_RUN;
          S_RUN: begin
            if (m_pc == TD - 1) begin
              m_pc = 0;
              m_total = m_total - 1;
              if (m_total == 0) m_st = S_DONE;
              else if (pr) m_st = S_PAUSE;
            end else begin
              m_pc++;
              if (pr) m_st = S_PAUSE;
            end
          end
          S_PAUSE: if (pl) m_st = S_RUN;
          default: ;
        endcase
      end
      hL = {hL[1:0], BTNL};
      hR = {hR[1:0], BTNR};
      hD = {hD[1:0], BTND};
    end
  end

  logic [25:0] exp_v, act_v;

  always @(negedge CLK) begin
    if (chk_en) begin
      exp_v = {(m_st == S_DONE), 5'(m_data), 3'(m_dig), (m_dp != 0), model_cnt()};
      act_v = {ALARM, data, digit, setdp, cnt_act()};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // returns at the negedge after the edge where the command takes effect
  task automatic press(input logic l, input logic r, input logic d);
    BTNL = l; BTNR = r; BTND = d;
    @(negedge CLK);
    BTNL = 1'b0; BTNR = 1'b0; BTND = 1'b0;
    wait_n(2);
  endtask

  typedef struct {
    logic [7:0]  sw;
    logic [15:0] cnt;
  } load_vec_t;

  typedef struct {
    logic [4:0] dat;
    logic [2:0] dig;
    logic       dp;
  } scan_vec_t;

  load_vec_t lv[5];
  scan_vec_t sv[4];
  bit found;

  initial begin
    lv[0] = '{8'h01, 16'h0100};
    lv[1] = '{8'hFA, 16'h9900};
    lv[2] = '{8'h10, 16'h1000};
    lv[3] = '{8'h9F, 16'h9900};
    lv[4] = '{8'hC7, 16'h9700};
    sv[0] = '{5'd4, 3'd1, 1'b0};
    sv[1] = '{5'd3, 3'd2, 1'b0};
    sv[2] = '{5'd2, 3'd3, 1'b1};
    sv[3] = '{5'd1, 3'd4, 1'b0};

    RST = 1'b1; BTNL = 1'b0; BTNR = 1'b0; BTND = 1'b0; SW = 8'h00;
    wait_n(3);
    chk("reset_out", {ALARM, data, digit, setdp}, 32'h0);
    chk("reset_cnt", cnt_act(), 32'h0);
    RST = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      SW = lv[i].sw;
      press(1'b0, 1'b0, 1'b1);
      chk("load_cnt", cnt_act(), lv[i].cnt);
      chk("load_alarm", ALARM, 0);
    end

    // load and run to alarm
    SW = 8'h01;
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    chk("run_start", cnt_act(), 16'h0100);
    wait_n(9);
    chk("run_9", cnt_act(), 16'h0100);
    wait_n(1);
    chk("run_10", cnt_act(), 16'h0059);
    wait_n(10);
    chk("run_20", cnt_act(), 16'h0058);
    wait_n(579);
    chk("run_599_alarm", ALARM, 0);
    chk("run_599_cnt", cnt_act(), 16'h0001);
    wait_n(1);
    chk("run_600_alarm", ALARM, 1);
    chk("run_600_cnt", cnt_act(), 16'h0000);
    press(1'b1, 1'b1, 1'b0);
    wait_n(20);
    chk("done_hold_alarm", ALARM, 1);
    chk("done_hold_cnt", cnt_act(), 16'h0000);

    // pause with prescaler held at 6, resume
    press(1'b0, 1'b0, 1'b1);
    chk("reload_alarm", ALARM, 0);
    press(1'b1, 1'b0, 1'b0);
    wait_n(3);
    press(1'b0, 1'b1, 1'b0);
    wait_n(50);
    chk("pause_hold", cnt_act(), 16'h0100);
    press(1'b1, 1'b0, 1'b0);
    wait_n(3);
    chk("resume_3", cnt_act(), 16'h0100);
    wait_n(1);
    chk("resume_4", cnt_act(), 16'h0059);

    // borrow chain
    SW = 8'h10;
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    wait_n(10);
    chk("borrow_1000", cnt_act(), 16'h0959);
    wait_n(590);
    chk("borrow_0900", cnt_act(), 16'h0900);
    wait_n(10);
    chk("borrow_0859", cnt_act(), 16'h0859);

    // zero start ignored
    SW = 8'h00;
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    wait_n(30);
    chk("zero_alarm", ALARM, 0);
    chk("zero_cnt", cnt_act(), 16'h0000);

    // load and start in the same cycle while running
    SW = 8'h01;
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    wait_n(15);
    SW = 8'h23;
    press(1'b1, 1'b0, 1'b1);
    chk("simul_cnt", cnt_act(), 16'h2300);
    wait_n(30);
    chk("simul_idle", cnt_act(), 16'h2300);

    // bring count to 12:34 and pause there for the scan check
    SW = 8'h13;
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    wait_n(258);
    press(1'b0, 1'b1, 1'b0);
    chk("scan_cnt", cnt_act(), 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_sc == 0 && m_dig == 1) found = 1'b1;
      else @(negedge CLK);
    end
    chk("scan_align", found, 1);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_order", {data, digit, setdp}, {sv[i].dat, sv[i].dig, sv[i].dp});
        @(negedge CLK);
      end
    end

    // reset while running
    press(1'b1, 1'b0, 1'b0);
    wait_n(5);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_out", {ALARM, data, digit, setdp}, 32'h0);
    chk("rst_cnt", cnt_act(), 16'h0);
    RST = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      BTNL = ($urandom % 6 == 0);
      BTNR = ($urandom % 25 == 0);
      BTND = ($urandom % 150 == 0);
      case ($urandom % 4)
        0: SW = 8'h00;
        1: SW = 8'h01;
        default: SW = 8'($urandom);
      endcase
      RST = ($urandom % 1500 == 0);
      @(negedge CLK);
    end
    RST = 1'b0; BTNL = 1'b0; BTNR = 1'b0; BTND = 1'b0;
    wait_n(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
